// File: rtl/avalon_traffic_master.sv
// Scripted Avalon-MM master: queues read/write commands and issues them one at a time.
// Optional feature macro READ_CHECK_EN stores per-command expected read data and counts mismatches.
module avalon_traffic_master #(
  parameter  int ADDR_W     = 32,
  parameter  int DATA_W     = 32,
  parameter  int FIFO_DEPTH = 8,
  parameter  int TIMEOUT    = 1024,
  localparam int BE_W       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [BE_W-1:0]   cmd_be,
  input  logic [DATA_W-1:0] cmd_expect,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              err_timeout,
  output logic [15:0]       txn_count,
  output logic [15:0]       mismatch_count,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  output logic [BE_W-1:0]   byteenable,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
`ifdef READ_CHECK_EN
    logic [DATA_W-1:0] exp_data;
`endif
  } cmd_t;

  typedef enum logic {S_IDLE, S_BUS} state_t;

  state_t            state_q, state_d;
  cmd_t              mem_q [FIFO_DEPTH];
  cmd_t              cmd_in, head;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] writedata_q, writedata_d, rsp_data_q, rsp_data_d;
  logic [BE_W-1:0]   byteenable_q, byteenable_d;
  logic              read_q, read_d, write_q, write_d;
  logic              rsp_valid_q, rsp_valid_d, err_q, err_d;
  logic [15:0]       txn_q, txn_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic              push, pop, complete, timeout_hit;

  always_comb begin
    cmd_in       = '0;
    cmd_in.write = cmd_write;
    cmd_in.addr  = cmd_addr;
    cmd_in.wdata = cmd_wdata;
    cmd_in.be    = cmd_be;
`ifdef READ_CHECK_EN
    cmd_in.exp_data = cmd_expect;
`endif
  end

  assign head        = mem_q[rd_ptr_q];
  assign push        = cmd_valid && cmd_ready;
  assign pop         = (state_q == S_IDLE) && (count_q != '0);
  assign complete    = (state_q == S_BUS) && !waitrequest;
  assign timeout_hit = (TIMEOUT != 0) && (state_q == S_BUS) && waitrequest && (wait_q == TO_LAST);

  // FSM process 1: state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM process 2: next state
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop) state_d = S_BUS;
      S_BUS:   if (complete || timeout_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM process 3: outputs (bus fields are registered so they stay stable through a stall)
  always_comb begin
    cmd_ready    = (count_q != CW'(FIFO_DEPTH));
    busy         = (count_q != '0) || (state_q == S_BUS);
    read_d       = read_q;
    write_d      = write_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    wait_d       = wait_q;
    if (pop) begin
      read_d       = !head.write;
      write_d      = head.write;
      address_d    = head.addr;
      writedata_d  = head.wdata;
      byteenable_d = head.be;
      wait_d       = '0;
    end else if (complete || timeout_hit) begin
      read_d  = 1'b0;
      write_d = 1'b0;
    end else if (state_q == S_BUS) begin
      wait_d = wait_q + TW'(1);
    end
  end

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    rsp_valid_d = complete && read_q;
    rsp_data_d  = (complete && read_q) ? readdata : rsp_data_q;
    txn_d       = complete ? txn_q + 16'd1 : txn_q;
    err_d       = err_q || timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      wait_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      txn_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      read_q       <= read_d;
      write_q      <= write_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      wait_q       <= wait_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      txn_q        <= txn_d;
      err_q        <= err_d;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

`ifdef READ_CHECK_EN
  logic [DATA_W-1:0] exp_q, exp_d, lane_mask;
  logic [15:0]       mis_q, mis_d;

  always_comb begin
    exp_d = pop ? head.exp_data : exp_q;
    for (int i = 0; i < BE_W; i++) lane_mask[i*8 +: 8] = {8{byteenable_q[i]}};
    mis_d = mis_q;
    if (complete && read_q && (((readdata ^ exp_q) & lane_mask) != '0) && (mis_q != 16'hFFFF))
      mis_d = mis_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q <= '0;
      mis_q <= '0;
    end else begin
      exp_q <= exp_d;
      mis_q <= mis_d;
    end
  end

  assign mismatch_count = mis_q;
`else
  logic unused_expect;
  assign unused_expect  = ^cmd_expect;
  assign mismatch_count = 16'h0000;
`endif

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign err_timeout = err_q;
  assign txn_count   = txn_q;
  assign address     = address_q;
  assign read        = read_q;
  assign write       = write_q;
  assign writedata   = writedata_q;
  assign byteenable  = byteenable_q;

endmodule

// File: tb/tb_avalon_traffic_master.sv
// Directed bench for avalon_traffic_master (FIFO_DEPTH=8, TIMEOUT=16); read-check tests follow READ_CHECK_EN.
module tb_avalon_traffic_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata, cmd_expect;
  logic [3:0]  cmd_be;
  logic        rsp_valid, busy, err_timeout;
  logic [31:0] rsp_data;
  logic [15:0] txn_count, mismatch_count;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest;
  logic [3:0]  byteenable;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;
  txn_t mon_q[$];

  avalon_traffic_master #(
    .ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(8), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be), .cmd_expect(cmd_expect),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .err_timeout(err_timeout),
    .txn_count(txn_count), .mismatch_count(mismatch_count),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
  );

  always #5 clk = ~clk;

  // Bus values seen at the falling edge hold until the next rising edge, where a completion lands.
  always @(negedge clk) begin
    if (!reset && (read || write) && !waitrequest)
      mon_q.push_back('{wr: write, addr: address, data: write ? writedata : readdata});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_be = '0; cmd_expect = '0; waitrequest = 1'b0; readdata = '0;
    tick(); tick();
    reset = 1'b0;
    mon_q.delete();
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [31:0] ex);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_be = be; cmd_expect = ex;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL push_ready: cmd_ready stayed low for addr %h", a);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({read, write, address, writedata, byteenable} !== '0) begin
      failures++; $display("FAIL reset_bus: r=%b w=%b a=%h wd=%h be=%b, need all 0",
                           read, write, address, writedata, byteenable);
    end
    checks++;
    if ({cmd_ready, busy, rsp_valid, err_timeout} !== 4'b1000) begin
      failures++; $display("FAIL reset_flags: ready/busy/rsp/err=%b, need 1000",
                           {cmd_ready, busy, rsp_valid, err_timeout});
    end
    checks++;
    if ({txn_count, mismatch_count, rsp_data} !== '0) begin
      failures++; $display("FAIL reset_counts: txn=%0d mis=%0d rsp_data=%h, need 0",
                           txn_count, mismatch_count, rsp_data);
    end
  endtask

  task automatic test_write();
    do_reset();
    push(1'b1, 32'h4, 32'hAABBCCDD, 4'b1100, '0);
    checks++;
    if (write !== 1'b0) begin failures++; $display("FAIL wr_latency: write=%b one cycle early, need 0", write); end
    tick();
    checks++;
    if ({write, read, address, writedata, byteenable} !== {1'b1, 1'b0, 32'h4, 32'hAABBCCDD, 4'b1100}) begin
      failures++; $display("FAIL wr_fields: w=%b r=%b a=%h d=%h be=%b, need 1 0 4 aabbccdd 1100",
                           write, read, address, writedata, byteenable);
    end
    tick();
    checks++;
    if ({write, rsp_valid, txn_count} !== {1'b0, 1'b0, 16'd1}) begin
      failures++; $display("FAIL wr_done: w=%b rsp_valid=%b txn=%0d, need 0 0 1", write, rsp_valid, txn_count);
    end
  endtask

  task automatic test_read_stall();
    do_reset();
    waitrequest = 1'b1;
    push(1'b0, 32'h4, '0, 4'hF, '0);
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({read, write, address, byteenable} !== {1'b1, 1'b0, 32'h4, 4'hF}) begin
        failures++; $display("FAIL rd_hold[%0d]: r=%b w=%b a=%h be=%b, need 1 0 4 1111",
                             k, read, write, address, byteenable);
      end
      if (k == 3) begin waitrequest = 1'b0; readdata = 32'hAABB0000; end
      tick();
    end
    readdata = 32'hDEADBEEF;
    checks++;
    if ({read, rsp_valid, rsp_data, txn_count} !== {1'b0, 1'b1, 32'hAABB0000, 16'd1}) begin
      failures++; $display("FAIL rd_rsp: r=%b rsp_valid=%b data=%h txn=%0d, need 0 1 aabb0000 1",
                           read, rsp_valid, rsp_data, txn_count);
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_data} !== {1'b0, 32'hAABB0000}) begin
      failures++; $display("FAIL rd_pulse: rsp_valid=%b data=%h, need 0 aabb0000", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_fifo_full();
    int cyc;
    do_reset();
    waitrequest = 1'b1;
    for (int i = 0; i < 9; i++) push(1'b1, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 4'hF, '0);
    checks++;
    if ({cmd_ready, busy, write, address} !== {1'b0, 1'b1, 1'b1, 32'h100}) begin
      failures++; $display("FAIL fifo_full: ready=%b busy=%b w=%b a=%h, need 0 1 1 100",
                           cmd_ready, busy, write, address);
    end
    waitrequest = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin tick(); cyc++; end
    checks++;
    if (cyc !== 17) begin
      failures++; $display("FAIL fifo_drain_cycles: took %0d cycles, need 17", cyc);
    end
    checks++;
    if (mon_q.size() !== 9 || txn_count !== 16'd9) begin
      failures++; $display("FAIL fifo_count: seen=%0d txn=%0d, need 9 9", mon_q.size(), txn_count);
    end
    for (int i = 0; i < 9 && i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[i].addr !== 32'h100 + 32'(4 * i) || mon_q[i].data !== 32'h1000 + 32'(i) || mon_q[i].wr !== 1'b1) begin
        failures++; $display("FAIL fifo_order[%0d]: a=%h d=%h, need %h %h", i, mon_q[i].addr,
                             mon_q[i].data, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i));
      end
    end
  endtask

  task automatic test_timeout();
    int cyc;
    do_reset();
    waitrequest = 1'b1;
    push(1'b0, 32'h40, '0, 4'hF, '0);
    push(1'b1, 32'h44, 32'h55, 4'hF, '0);
    cyc = 0;
    while (read && cyc < 40) begin tick(); cyc++; end
    checks++;
    if (cyc !== 16) begin failures++; $display("FAIL to_cycles: read high %0d stall cycles, need 16", cyc); end
    checks++;
    if ({err_timeout, rsp_valid, txn_count} !== {1'b1, 1'b0, 16'd0}) begin
      failures++; $display("FAIL to_flags: err=%b rsp_valid=%b txn=%0d, need 1 0 0",
                           err_timeout, rsp_valid, txn_count);
    end
    waitrequest = 1'b0;
    cyc = 0;
    while (txn_count != 16'd1 && cyc < 20) begin tick(); cyc++; end
    checks++;
    if (txn_count !== 16'd1 || err_timeout !== 1'b1 || mon_q.size() !== 1) begin
      failures++; $display("FAIL to_next: txn=%0d err=%b seen=%0d, need 1 1 1", txn_count, err_timeout, mon_q.size());
    end else begin
      checks++;
      if (mon_q[0].wr !== 1'b1 || mon_q[0].addr !== 32'h44 || mon_q[0].data !== 32'h55) begin
        failures++; $display("FAIL to_next_fields: wr=%b a=%h d=%h, need 1 44 55",
                             mon_q[0].wr, mon_q[0].addr, mon_q[0].data);
      end
    end
  endtask

  task automatic wait_rsp(input string name);
    int cyc = 0;
    while (!rsp_valid && cyc < 20) begin tick(); cyc++; end
    if (!rsp_valid) begin
      checks++; failures++;
      $display("FAIL %s: rsp_valid never rose", name);
    end
  endtask

  task automatic test_read_check();
    logic [15:0] exp_mis;
    do_reset();
    readdata = 32'hFFFFCCDD;
    push(1'b0, 32'h4, '0, 4'b0011, 32'h0000CCDD);
    wait_rsp("rc_match_wait");
    checks++;
    if ({rsp_data, mismatch_count} !== {32'hFFFFCCDD, 16'd0}) begin
      failures++; $display("FAIL rc_match: data=%h mis=%0d, need ffffccdd 0", rsp_data, mismatch_count);
    end
    tick();
    push(1'b0, 32'h4, '0, 4'b0011, 32'h0000CCDE);
    wait_rsp("rc_miss_wait");
`ifdef READ_CHECK_EN
    exp_mis = 16'd1;
`else
    exp_mis = 16'd0;
`endif
    checks++;
    if (mismatch_count !== exp_mis) begin
      failures++; $display("FAIL rc_miss: mis=%0d, need %0d", mismatch_count, exp_mis);
    end
  endtask

  task automatic test_zero_be();
    do_reset();
    push(1'b1, 32'h8, 32'h12345678, 4'b0000, '0);
    tick();
    checks++;
    if ({write, address, byteenable} !== {1'b1, 32'h8, 4'b0000}) begin
      failures++; $display("FAIL zbe_issue: w=%b a=%h be=%b, need 1 8 0000", write, address, byteenable);
    end
    tick();
    checks++;
    if ({write, txn_count} !== {1'b0, 16'd1}) begin
      failures++; $display("FAIL zbe_done: w=%b txn=%0d, need 0 1", write, txn_count);
    end
  endtask

  task automatic test_reset_mid_bus();
    do_reset();
    push(1'b1, 32'h10, 32'h1, 4'hF, '0);
    tick(); tick();
    checks++;
    if (txn_count !== 16'd1) begin failures++; $display("FAIL rst_pre: txn=%0d, need 1", txn_count); end
    waitrequest = 1'b1;
    push(1'b0, 32'h20, '0, 4'hF, '0);
    push(1'b1, 32'h24, 32'h2, 4'hF, '0);
    tick();
    checks++;
    if ({read, address} !== {1'b1, 32'h20}) begin
      failures++; $display("FAIL rst_stall: r=%b a=%h, need 1 20", read, address);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({read, write, busy, cmd_ready, rsp_valid, err_timeout, txn_count} !== {6'b000100, 16'd0}) begin
      failures++; $display("FAIL rst_mid: r=%b w=%b busy=%b ready=%b rsp=%b err=%b txn=%0d, need 0 0 0 1 0 0 0",
                           read, write, busy, cmd_ready, rsp_valid, err_timeout, txn_count);
    end
    reset = 1'b0;
    waitrequest = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({read, write, busy, rsp_valid, txn_count} !== {4'b0000, 16'd0}) begin
      failures++; $display("FAIL rst_after: r=%b w=%b busy=%b rsp=%b txn=%0d, need 0 0 0 0 0",
                           read, write, busy, rsp_valid, txn_count);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_stall();
    test_fifo_full();
    test_timeout();
    test_read_check();
    test_zero_be();
    test_reset_mid_bus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
